// File: rtl/cpu_clk_pkg.sv
// -----------------------------------------------------------------------------
// cpu_clk_pkg
//   Shared types for the CPU clock-enable controller: the controller FSM state
//   encoding and its width. Imported by the interface and by cpu_clk_ctrl.
// -----------------------------------------------------------------------------
package cpu_clk_pkg;

   localparam int STATE_W = 2;

   // Encoding is visible on the state output, so the values are fixed.
   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      TRAP = 2'd3
   } state_e;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl_if
//   Bundles the control inputs and status outputs of cpu_clk_ctrl.
//   master : board/CPU side, drives run_sw, btn_step, halt_req, div_n
//   slave  : the controller, drives cpu_ce, state, tick_led, ce_cnt
//   Parameters DIV_W / CNT_W must match those of the attached cpu_clk_ctrl.
// -----------------------------------------------------------------------------
interface cpu_clk_ctrl_if #(
   parameter int DIV_W = 32,
   parameter int CNT_W = 32
);
   import cpu_clk_pkg::*;

   logic               run_sw;    // free-run switch, asynchronous
   logic               btn_step;  // single-step button, asynchronous
   logic               halt_req;  // CPU halt request, synchronous to clk
   logic [DIV_W-1:0]   div_n;     // run-mode period in clk cycles
   logic               cpu_ce;    // one-cycle clock enable to the CPU
   logic [STATE_W-1:0] state;     // controller state
   logic               tick_led;  // toggles once per cpu_ce pulse
   logic [CNT_W-1:0]   ce_cnt;    // cpu_ce pulses since reset (wrapping)

   modport master (
      output run_sw, btn_step, halt_req, div_n,
      input  cpu_ce, state, tick_led, ce_cnt
   );

   modport slave (
      input  run_sw, btn_step, halt_req, div_n,
      output cpu_ce, state, tick_led, ce_cnt
   );

endinterface

// File: rtl/cpu_clk_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Programmable period divider producing a one-cycle tick instead of a
//   toggled clock. The counter runs 0..P-1 and wraps, tick is high while the
//   count equals P-1. P is div_n, with div_n of 0 or 1 meaning P=1.
//   The period is sampled while clr is high and again at every wrap, so a
//   div_n change mid-period only affects the following period.
//
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clr    in  hold counter at 0 and keep reloading the period
//   div_n  in  requested period
//   tick   out high in the last cycle of each period (combinational)
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [DIV_W-1:0] div_n,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] per_q, per_d;
   logic [DIV_W-1:0] div_eff;

   always_comb begin
      div_eff = (div_n > DIV_W'(1)) ? div_n : DIV_W'(1);
      tick    = (cnt_q == per_q - DIV_W'(1));
      cnt_d   = cnt_q + DIV_W'(1);
      per_d   = per_q;
      if (clr || tick) begin
         cnt_d = '0;
         per_d = div_eff;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         per_q <= DIV_W'(1);
      end else begin
         cnt_q <= cnt_d;
         per_q <= per_d;
      end
   end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//   Generates the clock-enable for a slow-running CPU on a 100 MHz board.
//   IDLE waits for the run switch or a step-button press, RUN issues cpu_ce
//   once every P cycles (see tick_gen), STEP issues exactly one cpu_ce, and
//   TRAP parks the CPU after a halt request until the run switch is dropped.
//
//   cpu_ce is decided in a cycle and presented registered in the next one;
//   tick_led and ce_cnt follow one cycle after each cpu_ce pulse.
//
//   Build option: define CPU_CLK_CTRL_DEBOUNCE_EN to require DEBOUNCE_CYCLES
//   consecutive equal samples of the synchronised button before it is
//   accepted. Without it the synchronised level is used directly.
//
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   bus       slave modport of cpu_clk_ctrl_if (switch/button/halt/div_n in,
//             cpu_ce/state/tick_led/ce_cnt out)
// -----------------------------------------------------------------------------
module cpu_clk_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int DIV_W           = 32,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   cpu_clk_ctrl_if.slave  bus
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("cpu_clk_ctrl: DEBOUNCE_CYCLES must be at least 1");
   end

   // --------------------------------------------------------------------------
   // Input synchronisers for the two board inputs
   // --------------------------------------------------------------------------
   logic run_s1_q, run_s2_q;
   logic btn_s1_q, btn_s2_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, which is what makes the
   // two-stage synchroniser two stages rather than one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_s1_q <= 1'b0;
         run_s2_q <= 1'b0;
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
      end else begin
         run_s1_q <= bus.run_sw;
         run_s2_q <= run_s1_q;
         btn_s1_q <= bus.btn_step;
         btn_s2_q <= btn_s1_q;
      end
   end

   logic run_sync;
   logic btn_lvl;

   assign run_sync = run_s2_q;

   // --------------------------------------------------------------------------
   // Optional button debounce
   // --------------------------------------------------------------------------
`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            btn_db_q, btn_db_d;

   // db_cnt counts how many consecutive samples so far disagreed with the
   // accepted level; the DEBOUNCE_CYCLES-th disagreeing sample flips it.
   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      db_cnt_d = '0;
      btn_db_d = btn_db_q;
      if (btn_s2_q != btn_db_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = btn_s2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_q <= '0;
         btn_db_q <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         btn_db_q <= btn_db_d;
      end
   end

   assign btn_lvl = btn_db_q;
`else
   assign btn_lvl = btn_s2_q;
`endif

   // --------------------------------------------------------------------------
   // Step event: rising edge of the qualified button level
   // --------------------------------------------------------------------------
   logic btn_prev_q;
   logic step_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev_q <= 1'b0;
      end else begin
         btn_prev_q <= btn_lvl;
      end
   end

   // The previous level is tracked in every state, so a press that happens
   // during RUN or TRAP is consumed there and never replays later in IDLE.
   assign step_evt = btn_lvl & ~btn_prev_q;

   // --------------------------------------------------------------------------
   // Run-mode period generator
   // --------------------------------------------------------------------------
   state_e state_q, state_d;
   logic   tick;
   logic   tick_clr;

   // Held clear outside RUN, so entry starts at count 0 with a freshly
   // sampled period.
   assign tick_clr = (state_q != RUN);

   tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tick_clr),
      .div_n (bus.div_n),
      .tick  (tick)
   );

   // --------------------------------------------------------------------------
   // Controller FSM
   // --------------------------------------------------------------------------
   logic cpu_ce_q, cpu_ce_d;

   always_comb begin
      state_d  = state_q;
      cpu_ce_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (run_sync) begin
               state_d = RUN;
            end else if (step_evt) begin
               state_d  = STEP;
               cpu_ce_d = 1'b1;   // high exactly while state is STEP
            end
         end
         STEP: begin
            state_d = IDLE;
         end
         RUN: begin
            // A halt or an exit in the tick cycle swallows that pulse.
            if (bus.halt_req) begin
               state_d = TRAP;
            end else if (!run_sync) begin
               state_d = IDLE;
            end else begin
               cpu_ce_d = tick;
            end
         end
         TRAP: begin
            if (!run_sync) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cpu_ce_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cpu_ce_q <= cpu_ce_d;
      end
   end

   // --------------------------------------------------------------------------
   // Pulse indicators, updated the cycle after each cpu_ce pulse
   // --------------------------------------------------------------------------
   logic             tick_led_q, tick_led_d;
   logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;

   always_comb begin
      tick_led_d = tick_led_q ^ cpu_ce_q;
      ce_cnt_d   = ce_cnt_q + CNT_W'(cpu_ce_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_led_q <= 1'b0;
         ce_cnt_q   <= '0;
      end else begin
         tick_led_q <= tick_led_d;
         ce_cnt_q   <= ce_cnt_d;
      end
   end

   assign bus.cpu_ce   = cpu_ce_q;
   assign bus.state    = state_q;
   assign bus.tick_led = tick_led_q;
   assign bus.ce_cnt   = ce_cnt_q;

endmodule
